serial_subtractor: RTL

Bit-serial unsigned subtractor computing a − b − bin one bit per clock through a single full-subtractor cell, LSB first. It is the inverse-operation companion to the lab's combinational RippleCarryAdder: same operand and result widths, borrow in place of carry. It trades SIZE cycles of latency for one-bit datapath hardware, and uses a start/done handshake so a controller or testbench can sequence operations.

---
 rtl/serial_subtractor.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: {bout, diff} = a - b - bin, one bit per clock, LSB first,
// sequenced by a start/done handshake.
module serial_subtractor #(
    parameter int unsigned SIZE = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] diff,
    output logic            bout
);

    localparam int unsigned CW = $clog2(SIZE) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [SIZE-1:0] sa, sa_n;
    logic [SIZE-1:0] sb, sb_n;
    logic [SIZE-1:0] sr, sr_n;
    logic            br, br_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [SIZE-1:0] diff_n;
    logic            bout_n;
    logic            d_bit;
    logic            br_next;

    // Single full-subtractor cell on the current LSBs.
    assign d_bit   = sa[0] ^ sb[0] ^ br;
    assign br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else begin
            state <= state_n;
            sa    <= sa_n;
            sb    <= sb_n;
            sr    <= sr_n;
            br    <= br_n;
            cnt   <= cnt_n;
            diff  <= diff_n;
            bout  <= bout_n;
        end
    end

    always_comb begin
        state_n = state;
        sa_n    = sa;
        sb_n    = sb;
        sr_n    = sr;
        br_n    = br;
        cnt_n   = cnt;
        diff_n  = diff;
        bout_n  = bout;
        case (state)
            IDLE, DONE: begin
                // DONE accepts start just like IDLE so operations can run back-to-back.
                if (start) begin
                    sa_n    = a;
                    sb_n    = b;
                    br_n    = bin;
                    cnt_n   = '0;
                    sr_n    = '0;
                    state_n = BUSY;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                sa_n  = sa >> 1;
                sb_n  = sb >> 1;
                sr_n  = {d_bit, sr[SIZE-1:1]};
                br_n  = br_next;
                cnt_n = cnt + CW'(1);
                // Results are published only on the final bit so they never show partial values.
                if (cnt == CW'(SIZE - 1)) begin
                    diff_n  = {d_bit, sr[SIZE-1:1]};
                    bout_n  = br_next;
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
